op_sequencer: RTL

- Controller that sequences the `operation` datapath over a window of operand-memory entries.
- Issues operand1/operand2 read addresses, tracks the datapath latency, and drives the write-enable and address for result_mem.
- Reports busy/done to the bench or host.
- Replaces free-running address generation inside the datapath with a start/done-controlled, stallable schedule.

---
 rtl/op_seq_pkg.sv | 26 ++
 rtl/op_seq_delay.sv | 55 +++++
 rtl/op_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/op_seq_pkg.sv
// ---------------------------------------------------------------------------
// op_seq_pkg
// Shared types and constants for the op_sequencer controller.
//   state_t        : controller FSM states (IDLE, RUN, DRAIN, DONE)
//   OP_LATENCY_MAX : largest supported datapath latency
//   PERF_CNT_W     : width of the optional performance counters
//   calc_addr_w()  : address width for a given memory depth
// ---------------------------------------------------------------------------
package op_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OP_LATENCY_MAX = 4;
    localparam int PERF_CNT_W     = 16;

    // A depth of 2 still needs one address bit.
    function automatic int calc_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/op_seq_delay.sv
// ---------------------------------------------------------------------------
// op_seq_delay
// LATENCY-stage shift register carrying {valid, addr} from operand issue to
// result write. It shifts every cycle; there is no stall input, so in-flight
// elements always drain.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset, clears every stage
//   in_valid  in   element issued this cycle
//   in_addr   in   address of the issued element
//   out_valid out  element leaves the line this cycle (result write enable)
//   out_addr  out  address of the most recent valid element to leave
// ---------------------------------------------------------------------------
module op_seq_delay #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [LATENCY-1:0] valid_q;
    logic [ADDR_W-1:0]  addr_q [LATENCY];

    // Each address stage only loads when a valid element enters it, so the
    // last stage keeps the address of the most recent real write while
    // bubbles pass through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                addr_q[0] <= in_addr;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    addr_q[i] <= addr_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_addr  = addr_q[LATENCY-1];

endmodule

// File: rtl/op_sequencer.sv
// ---------------------------------------------------------------------------
// op_sequencer
// Sequences the operation datapath over a window of operand-memory entries:
// issues operand read addresses, tracks datapath latency through
// op_seq_delay, and drives result_mem write enable/address.
//
// Optional build macro: OP_SEQ_PERF_EN adds stall_cycles_o / run_cycles_o.
//
// Ports:
//   clk_i            in   clock, rising edge
//   rst_i            in   asynchronous active-high reset (aborts a run)
//   start_i          in   start request, only looked at in IDLE
//   base_addr_i      in   first operand address
//   count_i          in   element count, saturated to MEM_DEPTH
//   stall_i          in   holds off new issues while high
//   operand1_addr_o  out  operand1 read address
//   operand2_addr_o  out  operand2 read address (same as operand1)
//   operand_valid_o  out  element issued this cycle
//   result_we_o      out  result_mem write enable
//   result_addr_o    out  result_mem write address
//   busy_o           out  high in RUN and DRAIN
//   done_o           out  one-cycle completion pulse
//   stall_cycles_o   out  (OP_SEQ_PERF_EN) RUN cycles with stall_i high
//   run_cycles_o     out  (OP_SEQ_PERF_EN) cycles with busy_o high
//
// Handshake: start_i is accepted on a rising edge where the FSM is in IDLE
// and start_i=1; requests in any other state are dropped, not queued. Each
// accepted start produces exactly one done_o pulse unless reset intervenes.
// operand_valid_o has no ready: an element is issued in every RUN cycle
// with stall_i=0, and its result_we_o follows exactly OP_LATENCY cycles
// later regardless of stall_i.
// ---------------------------------------------------------------------------
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int  MEM_DEPTH  = 8,
    parameter int  MEM_WIDTH  = 32,
    parameter int  OP_LATENCY = 1,
    localparam int ADDR_W     = calc_addr_w(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] operand1_addr_o,
    output logic [ADDR_W-1:0] operand2_addr_o,
    output logic              operand_valid_o,
    output logic              result_we_o,
    output logic [ADDR_W-1:0] result_addr_o,
    output logic              busy_o,
    output logic              done_o
`ifdef OP_SEQ_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles_o,
    output logic [PERF_CNT_W-1:0] run_cycles_o
`endif
);

    // Elaboration-time parameter sanity checks.
    if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("op_sequencer: MEM_DEPTH must be a power of 2, at least 2");
    end
    if (OP_LATENCY < 1 || OP_LATENCY > OP_LATENCY_MAX) begin : g_bad_latency
        $error("op_sequencer: OP_LATENCY out of range 1..4");
    end
    if (MEM_WIDTH < 1) begin : g_bad_width
        $error("op_sequencer: MEM_WIDTH must be positive");
    end

    localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [2:0]      DRAIN_INIT = 3'(OP_LATENCY - 1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   n_sat;
    logic [2:0]        drain_cnt;
    logic              accept;
    logic              issue;
    logic              last_issue;

    assign n_sat      = (count_i > DEPTH_CNT) ? DEPTH_CNT : count_i;
    assign accept     = (state == IDLE) && start_i;
    assign issue      = (state == RUN) && !stall_i;
    assign last_issue = issue && (remaining == CNT_ONE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = (n_sat == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_n = DRAIN;
                end
            end
            // The last element is issued on the edge that enters DRAIN and
            // reaches result_we_o OP_LATENCY-1 edges later, so DRAIN lasts
            // exactly OP_LATENCY cycles.
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ---------------- issue counters ----------------
    // The pointer does not advance on the final issue, so the operand
    // addresses keep showing the last issued address once RUN ends. A
    // zero-length request leaves them untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr       <= '0;
            remaining <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                remaining <= n_sat;
                if (n_sat != '0) begin
                    ptr <= base_addr_i;
                end
            end
            if (issue) begin
                remaining <= remaining - CNT_ONE;
                if (!last_issue) begin
                    ptr <= ptr + ADDR_W'(1);
                end
            end
            if (last_issue) begin
                drain_cnt <= DRAIN_INIT;
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 3'd1;
            end
        end
    end

    // ---------------- result path ----------------
    op_seq_delay #(
        .LATENCY (OP_LATENCY),
        .ADDR_W  (ADDR_W)
    ) u_delay (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (issue),
        .in_addr   (ptr),
        .out_valid (result_we_o),
        .out_addr  (result_addr_o)
    );

    assign operand1_addr_o = ptr;
    assign operand2_addr_o = ptr;
    assign operand_valid_o = issue;
    assign busy_o          = (state == RUN) || (state == DRAIN);
    assign done_o          = (state == DONE);

`ifdef OP_SEQ_PERF_EN
    // ---------------- performance counters ----------------
    localparam logic [PERF_CNT_W-1:0] PERF_ONE = PERF_CNT_W'(1);

    logic [PERF_CNT_W-1:0] stall_cnt;
    logic [PERF_CNT_W-1:0] run_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
        end else begin
            if (busy_o && run_cnt != '1) begin
                run_cnt <= run_cnt + PERF_ONE;
            end
            if (state == RUN && stall_i && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + PERF_ONE;
            end
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign run_cycles_o   = run_cnt;
`endif

endmodule
